ram_access_master: RTL

- Initiator/controller that drives the single-port parity RAM block from a host-side request stream.
- Converts host burst requests into cycle-by-cycle blk_sel/rd_en/wr_en/addr/din strobes on the RAM port.
- Tracks RAM read latency, returns read data with a parity-check flag, and counts parity errors.
- Sits between the host/bus interface logic and the RAM instance.

---
 rtl/ram_access_master.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/ram_access_master.sv
// Burst master for the single-port parity RAM: turns host read/write bursts into per-cycle
// RAM strobes, tracks read latency with a token pipe, and flags/counts parity errors.
module ram_access_master #(
  parameter int unsigned MEM_WIDTH  = 16,
  parameter int unsigned ADD_SIZE   = 10,
  parameter int unsigned LEN_W      = 4,
  parameter int unsigned RD_LATENCY = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  // Host request
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic                 req_wr_i,
  input  logic [ADD_SIZE-1:0]  req_addr_i,
  input  logic [LEN_W-1:0]     req_len_i,
  // Host write data
  input  logic                 wdata_valid_i,
  output logic                 wdata_ready_o,
  input  logic [MEM_WIDTH-1:0] wdata_i,
  // Host read response
  output logic                 rsp_valid_o,
  output logic [MEM_WIDTH-1:0] rsp_data_o,
  output logic                 rsp_perr_o,
  output logic                 rsp_last_o,
  output logic                 done_o,
  output logic [7:0]           perr_cnt_o,
  // RAM port
  output logic                 ram_blk_sel_o,
  output logic                 ram_rd_en_o,
  output logic                 ram_wr_en_o,
  output logic [ADD_SIZE-1:0]  ram_addr_o,
  output logic [MEM_WIDTH-1:0] ram_din_o,
  input  logic [MEM_WIDTH-1:0] ram_dout_i,
  input  logic                 ram_parity_i
);

  typedef enum logic [1:0] {StIdle, StWrite, StRead, StDrain} state_e;

  state_e                 state_q, state_d;
  logic [ADD_SIZE-1:0]    addr_q, addr_d;
  logic [LEN_W-1:0]       len_q, len_d;
  logic [LEN_W-1:0]       cnt_q, cnt_d;
  logic                   ram_rd_en_q, ram_rd_en_d;
  logic                   ram_wr_en_q, ram_wr_en_d;
  logic                   blk_sel_q, blk_sel_d;
  logic [ADD_SIZE-1:0]    ram_addr_q, ram_addr_d;
  logic [MEM_WIDTH-1:0]   ram_din_q, ram_din_d;
  logic                   rd_last_q, rd_last_d;
  logic                   done_q, done_d;
  logic [RD_LATENCY-1:0]  tok_v_q, tok_v_d;
  logic [RD_LATENCY-1:0]  tok_last_q, tok_last_d;
  logic                   rsp_valid_q, rsp_valid_d;
  logic [MEM_WIDTH-1:0]   rsp_data_q, rsp_data_d;
  logic                   rsp_perr_q, rsp_perr_d;
  logic                   rsp_last_q, rsp_last_d;
  logic [7:0]             perr_cnt_q, perr_cnt_d;
  logic                   tok_out_v, tok_out_last;

  assign tok_out_v    = tok_v_q[RD_LATENCY-1];
  assign tok_out_last = tok_last_q[RD_LATENCY-1];

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    len_d       = len_q;
    cnt_d       = cnt_q;
    ram_rd_en_d = 1'b0;
    ram_wr_en_d = 1'b0;
    ram_addr_d  = ram_addr_q;
    ram_din_d   = ram_din_q;
    rd_last_d   = 1'b0;
    done_d      = 1'b0;

    // Token i is valid in the cycle i+1 after its read strobe; the last stage lines up
    // with ram_dout being valid.
    tok_v_d[0]    = ram_rd_en_q;
    tok_last_d[0] = rd_last_q;
    for (int unsigned i = 1; i < RD_LATENCY; i++) begin
      tok_v_d[i]    = tok_v_q[i-1];
      tok_last_d[i] = tok_last_q[i-1];
    end

    rsp_valid_d = tok_out_v;
    rsp_last_d  = tok_out_v & tok_out_last;
    rsp_perr_d  = tok_out_v & ((^ram_dout_i) != ram_parity_i);
    rsp_data_d  = tok_out_v ? ram_dout_i : rsp_data_q;

    perr_cnt_d = perr_cnt_q;
    if (rsp_valid_q && rsp_perr_q && (perr_cnt_q != 8'hFF)) begin
      perr_cnt_d = perr_cnt_q + 8'd1;
    end

    unique case (state_q)
      StIdle: begin
        if (req_valid_i) begin
          addr_d = req_addr_i;
          len_d  = req_len_i;
          cnt_d  = '0;
          if (req_wr_i) begin
            state_d = StWrite;
          end else begin
            // Issue beat 0 straight away so reads start the cycle after acceptance.
            ram_rd_en_d = 1'b1;
            ram_addr_d  = req_addr_i;
            rd_last_d   = (req_len_i == '0);
            addr_d      = req_addr_i + ADD_SIZE'(1);
            cnt_d       = LEN_W'(1);
            state_d     = (req_len_i == '0) ? StDrain : StRead;
          end
        end
      end
      StWrite: begin
        if (wdata_valid_i) begin
          ram_wr_en_d = 1'b1;
          ram_addr_d  = addr_q;
          ram_din_d   = wdata_i;
          addr_d      = addr_q + ADD_SIZE'(1);
          cnt_d       = cnt_q + LEN_W'(1);
          if (cnt_q == len_q) begin
            done_d  = 1'b1;
            state_d = StIdle;
          end
        end
      end
      StRead: begin
        ram_rd_en_d = 1'b1;
        ram_addr_d  = addr_q;
        rd_last_d   = (cnt_q == len_q);
        addr_d      = addr_q + ADD_SIZE'(1);
        cnt_d       = cnt_q + LEN_W'(1);
        if (cnt_q == len_q) begin
          state_d = StDrain;
        end
      end
      StDrain: begin
        if (tok_out_v && tok_out_last) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    if (tok_out_v && tok_out_last) begin
      done_d = 1'b1;
    end
    blk_sel_d = ram_rd_en_d | ram_wr_en_d;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      addr_q      <= '0;
      len_q       <= '0;
      cnt_q       <= '0;
      ram_rd_en_q <= 1'b0;
      ram_wr_en_q <= 1'b0;
      blk_sel_q   <= 1'b0;
      ram_addr_q  <= '0;
      ram_din_q   <= '0;
      rd_last_q   <= 1'b0;
      done_q      <= 1'b0;
      tok_v_q     <= '0;
      tok_last_q  <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_perr_q  <= 1'b0;
      rsp_last_q  <= 1'b0;
      perr_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      ram_rd_en_q <= ram_rd_en_d;
      ram_wr_en_q <= ram_wr_en_d;
      blk_sel_q   <= blk_sel_d;
      ram_addr_q  <= ram_addr_d;
      ram_din_q   <= ram_din_d;
      rd_last_q   <= rd_last_d;
      done_q      <= done_d;
      tok_v_q     <= tok_v_d;
      tok_last_q  <= tok_last_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_perr_q  <= rsp_perr_d;
      rsp_last_q  <= rsp_last_d;
      perr_cnt_q  <= perr_cnt_d;
    end
  end

  assign req_ready_o   = (state_q == StIdle);
  assign wdata_ready_o = (state_q == StWrite);
  assign rsp_valid_o   = rsp_valid_q;
  assign rsp_data_o    = rsp_data_q;
  assign rsp_perr_o    = rsp_perr_q;
  assign rsp_last_o    = rsp_last_q;
  assign done_o        = done_q;
  assign perr_cnt_o    = perr_cnt_q;
  assign ram_blk_sel_o = blk_sel_q;
  assign ram_rd_en_o   = ram_rd_en_q;
  assign ram_wr_en_o   = ram_wr_en_q;
  assign ram_addr_o    = ram_addr_q;
  assign ram_din_o     = ram_din_q;

endmodule
